sr_dispatch: RTL
================

Name: sr_dispatch

Overview:
- Single-clock dispatcher that shares a pool of NUM iterative squareroot engines among one operand stream.
- Accepts operands on a valid/ready input and issues them to engines in strict round-robin order.
- Holds each result in a per-engine slot and returns results in issue order, tagged, on a valid/ready output.
- Sits between the request source and one clock group of squareroot instances; the top level ties each engine's active-high rst to ~rst_n.

Parameters:
I_WIDTH, 32, operand width
O_WIDTH, (I_WIDTH+1)>>1, result width
NUM, 4, number of engines managed (≥2)
TAG_W, 8, width of output sequence tag

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
en  input  1  1 = accept new operands; 0 = stop accepting, in-flight jobs drain
in_valid  input  1  operand valid
in_data  input  I_WIDTH  operand
in_ready  output  1  dispatcher can take operand this cycle
out_valid  output  1  result available
out_data  output  O_WIDTH  square root result
out_tag  output  TAG_W  sequence number of result (mod 2^TAG_W)
out_ready  input  1  consumer takes result
eng_din  output  I_WIDTH x [0:NUM-1]  operand to engine k
eng_newd  output  1 x [0:NUM-1]  one-cycle start pulse to engine k
eng_dout  input  O_WIDTH x [0:NUM-1]  engine k result
eng_done  input  1 x [0:NUM-1]  engine k one-cycle completion pulse, eng_dout valid that cycle
idle  output  1  no engine busy and no held result
err_spurious  output  1  sticky: eng_done seen on a non-busy engine

Behaviour:
- State per engine k: busy[k], res_vld[k], res[k] (O_WIDTH). Global: issue_ptr, ret_ptr (0..NUM-1), tag counter (TAG_W).
- Reset (async, rst_n=0): busy, res_vld, eng_newd, eng_din, out_tag, issue_ptr, ret_ptr and err_spurious all 0. Consequently out_valid=0, out_data=0. in_ready follows the combinational rule below.
- Slot state machine per engine: FREE (busy=0, res_vld=0) -> RUN on issue -> HELD on eng_done -> FREE on pop.
- in_ready = en & ~busy[issue_ptr] & ~res_vld[issue_ptr]. It has no combinational dependence on out_ready or in_valid.
- Accept (in_valid & in_ready) at cycle t:
  - eng_din[issue_ptr] <= in_data (held until the next issue to that engine).
  - eng_newd[issue_ptr] high for exactly cycle t+1.
  - busy set.
  - issue_ptr wraps NUM-1 -> 0.
- Completion: eng_done[k] & busy[k] -> res[k] <= eng_dout[k], res_vld[k] <= 1, busy[k] <= 0. Multiple engines may complete in the same cycle; all are captured.
- Spurious completion: eng_done[k] & ~busy[k] -> ignored, err_spurious <= 1 (cleared only by reset).
- Output path:
  - out_valid = res_vld[ret_ptr]; out_data = res[ret_ptr] when out_valid, else 0; out_tag = tag counter.
  - Pop (out_valid & out_ready): res_vld[ret_ptr] <= 0, ret_ptr wraps, tag increments (wraps 2^TAG_W-1 -> 0).
- Ordering: results leave strictly in acceptance order regardless of engine completion order. A later engine's finished result waits in its slot.
- Full: all NUM slots RUN or HELD -> in_ready=0. A slot freed by a pop in cycle t is issuable from cycle t+1.
- Simultaneous events: accept, completion on another engine, and pop may all occur in one cycle, and all take effect. Completion and pop on the same slot cannot coincide, because a pop requires res_vld.
- en=0 mid-stream: no new accepts; busy engines complete and results drain normally.
- idle = ~|busy & ~|res_vld.
- Reset mid-operation clears all state; any engine done arriving after reset counts as spurious.
- Latency: accept -> eng_newd 1 cycle; eng_done -> out_valid 1 cycle (when slot at ret_ptr).

Test Plan:
1. Reset with in_valid=0 -> out_valid=0, in_ready=1, eng_newd all 0, idle=1, err_spurious=0.
2. Single job: in_data=144 accepted -> eng_newd[0] pulses next cycle with eng_din[0]=144. Model returns 12 -> out_valid next cycle, out_data=12, out_tag=0. After pop, idle=1.
3. Out-of-order completion (NUM=4): issue 16,25,36,49; engines finish in order 3,2,1,0 -> outputs 4,5,6,7 with tags 0,1,2,3 in that order.
4. Backpressure: out_ready=0, offer 5 operands -> 4 accepted and in_ready=0 for the 5th. Pop once -> 5th accepted to engine 0 the next cycle; tags continue 4.
5. Tag wrap (TAG_W=2): 6 jobs -> tags 0,1,2,3,0,1.
6. Control and error: en=0 with 2 jobs in flight -> in_ready=0, both results still delivered, then idle=1. Spurious eng_done[2] on a free engine -> err_spurious=1, no output. Reset mid-job -> all state cleared.

Source files
------------

// File: rtl/sr_dispatch.sv
// sr_dispatch: shares NUM iterative square-root engines among one operand
// stream. Operands are issued round-robin; each engine's result is held in a
// per-engine slot and returned in issue order with a sequence tag.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   en              1 = accept new operands; 0 = in-flight jobs drain
//   in_valid/ready  operand handshake, in_data operand
//   out_valid/ready result handshake, out_data root, out_tag sequence number
//   eng_din/newd    operand and one-cycle start pulse per engine
//   eng_dout/done   result and one-cycle completion pulse per engine
//   idle            no engine busy and no held result
//   err_spurious    sticky: completion seen on a non-busy engine
module sr_dispatch #(
  parameter int unsigned I_WIDTH = 32,
  parameter int unsigned O_WIDTH = (I_WIDTH + 1) >> 1,
  parameter int unsigned NUM     = 4,
  parameter int unsigned TAG_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_valid,
  input  logic [I_WIDTH-1:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [O_WIDTH-1:0] out_data,
  output logic [TAG_W-1:0]   out_tag,
  input  logic               out_ready,
  output logic [I_WIDTH-1:0] eng_din  [0:NUM-1],
  output logic [NUM-1:0]     eng_newd,
  input  logic [O_WIDTH-1:0] eng_dout [0:NUM-1],
  input  logic [NUM-1:0]     eng_done,
  output logic               idle,
  output logic               err_spurious
);

  localparam int unsigned PW = (NUM > 1) ? $clog2(NUM) : 1;

  logic [NUM-1:0]     r_busy;
  logic [NUM-1:0]     r_res_vld;
  logic [O_WIDTH-1:0] r_res [0:NUM-1];
  logic [I_WIDTH-1:0] r_din [0:NUM-1];
  logic [NUM-1:0]     r_newd;
  logic [PW-1:0]      r_issue_ptr;
  logic [PW-1:0]      r_ret_ptr;
  logic [TAG_W-1:0]   r_tag;
  logic               r_err;

  logic               w_accept;
  logic               w_pop;

  assign in_ready  = en & ~r_busy[r_issue_ptr] & ~r_res_vld[r_issue_ptr];
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_res_vld[r_ret_ptr];
  assign out_data  = out_valid ? r_res[r_ret_ptr] : '0;
  assign out_tag   = r_tag;
  assign w_pop     = out_valid & out_ready;
  assign idle      = ~|r_busy & ~|r_res_vld;
  assign err_spurious = r_err;
  assign eng_newd  = r_newd;
  assign eng_din   = r_din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= '0;
      r_res_vld   <= '0;
      r_newd      <= '0;
      r_issue_ptr <= '0;
      r_ret_ptr   <= '0;
      r_tag       <= '0;
      r_err       <= 1'b0;
      for (int unsigned k = 0; k < NUM; k++) begin
        r_din[k] <= '0;
        r_res[k] <= '0;
      end
    end else begin
      r_newd <= '0;

      if (w_accept) begin
        r_din[r_issue_ptr]  <= in_data;
        r_newd[r_issue_ptr] <= 1'b1;
        r_busy[r_issue_ptr] <= 1'b1;
        r_issue_ptr <= (r_issue_ptr == PW'(NUM - 1)) ? '0 : r_issue_ptr + 1'b1;
      end

      // Completion qualifies on the pre-edge busy bit, so a done on the slot
      // being issued this cycle is spurious and cannot clear the new busy.
      for (int unsigned k = 0; k < NUM; k++) begin
        if (eng_done[k]) begin
          if (r_busy[k]) begin
            r_res[k]     <= eng_dout[k];
            r_res_vld[k] <= 1'b1;
            r_busy[k]    <= 1'b0;
          end else begin
            r_err <= 1'b1;
          end
        end
      end

      // A popped slot holds a result, so it is never the target of a
      // completion in the same cycle.
      if (w_pop) begin
        r_res_vld[r_ret_ptr] <= 1'b0;
        r_ret_ptr <= (r_ret_ptr == PW'(NUM - 1)) ? '0 : r_ret_ptr + 1'b1;
        r_tag     <= r_tag + 1'b1;
      end
    end
  end

endmodule
